// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch/decode handshake bundle between pc_sequencer, instruction memory and IF/ID.
interface pc_sequencer_if;
    logic        stall;
    logic        fetch_ack;
    logic        dec_valid;
    logic        jump;
    logic [25:0] jump_imm;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jr;
    logic [31:0] jr_target;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic [31:0] dec_pc;
    logic [31:0] dec_pcplus4;
    logic        if_valid;
    logic        flush;
    modport master (
        input  stall, fetch_ack, dec_valid, jump, jump_imm, branch_taken, branch_imm, jr, jr_target,
        output fetch_req, fetch_pc, dec_pc, dec_pcplus4, if_valid, flush
    );
    modport slave (
        output stall, fetch_ack, dec_valid, jump, jump_imm, branch_taken, branch_imm, jr, jr_target,
        input  fetch_req, fetch_pc, dec_pc, dec_pcplus4, if_valid, flush
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register, imem request/ack handshake and jump/jr/branch redirect resolution.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
    state_t      state, state_n;
    logic [31:0] pc, pc_n, dpc, dpc_n, tgt, tgt_n, base, target;
    logic        pend, pend_n, redir, valid;
    assign base   = dpc + 32'd4;
    assign target = bus.jr   ? {bus.jr_target[31:2], 2'b00} :
                    bus.jump ? {base[31:28], bus.jump_imm, 2'b00} :
                               base + {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
    assign redir  = bus.dec_valid & ~bus.stall & (bus.jr | bus.jump | bus.branch_taken);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
            dpc   <= RESET_PC;
            pend  <= 1'b0;
            tgt   <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            dpc   <= dpc_n;
            pend  <= pend_n;
            tgt   <= tgt_n;
        end
    // A word returned while a redirect is live or pending belongs to the wrong path and is dropped.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        dpc_n   = dpc;
        pend_n  = pend;
        tgt_n   = tgt;
        valid   = 1'b0;
        case (state)
            BOOT: state_n = FETCH;
            FETCH:
                if (bus.fetch_ack) begin
                    if (redir | pend) begin
                        pc_n   = redir ? target : tgt;
                        pend_n = 1'b0;
                    end else if (bus.stall) state_n = HOLD;
                    else begin
                        valid = 1'b1;
                        dpc_n = pc;
                        pc_n  = pc + 32'd4;
                    end
                end else if (redir) begin
                    pend_n = 1'b1;
                    tgt_n  = target;
                end
            HOLD: begin
                pc_n    = redir ? target : pc;
                state_n = bus.stall ? HOLD : FETCH;
            end
            default: state_n = BOOT;
        endcase
    end
    assign bus.fetch_req   = (state == FETCH);
    assign bus.fetch_pc    = pc;
    assign bus.dec_pc      = dpc;
    assign bus.dec_pcplus4 = base;
    assign bus.if_valid    = valid;
    assign bus.flush       = redir;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench; expectations queued with each stimulus, compared as outputs appear.
module tb_pc_sequencer;
    localparam int FPC = 0, DPC = 1, DP4 = 2, REQ = 3, IFV = 4, FLS = 5;
    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    logic clk, reset;
    int   n_vec = 0, n_err = 0;
    exp_t q_now[$], q_next[$];
    pc_sequencer_if sq ();
    pc_sequencer #(.RESET_PC(32'h0)) dut (.clk(clk), .reset(reset), .bus(sq.master));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [31:0] probe(int sel);
        case (sel)
            FPC:     return sq.fetch_pc;
            DPC:     return sq.dec_pc;
            DP4:     return sq.dec_pcplus4;
            REQ:     return {31'b0, sq.fetch_req};
            IFV:     return {31'b0, sq.if_valid};
            default: return {31'b0, sq.flush};
        endcase
    endfunction
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic now(string t, int s, logic [31:0] v);
        q_now.push_back('{tag: t, sel: s, val: v});
    endtask
    task automatic nxt(string t, int s, logic [31:0] v);
        q_next.push_back('{tag: t, sel: s, val: v});
    endtask
    task automatic cycle();
        exp_t e;
        #1;
        while (q_now.size() > 0) begin
            e = q_now.pop_front();
            chk(e.tag, probe(e.sel), e.val);
        end
        @(posedge clk);
        #1;
        while (q_next.size() > 0) begin
            e = q_next.pop_front();
            chk(e.tag, probe(e.sel), e.val);
        end
        @(negedge clk);
    endtask
    task automatic idle(logic ack);
        sq.stall = 0; sq.dec_valid = 0; sq.jump = 0; sq.jr = 0; sq.branch_taken = 0;
        sq.fetch_ack = ack;
    endtask
    task automatic redirect_to(logic [31:0] a);
        idle(1); sq.dec_valid = 1; sq.jr = 1; sq.jr_target = a;
        now("rd_flush", FLS, 1); nxt("rd_pc", FPC, a);
        cycle();
        idle(1);
        now("rd_ifv", IFV, 1); nxt("rd_dpc", DPC, a); nxt("rd_pc4", FPC, a + 4);
        cycle();
    endtask
    initial begin
        reset = 1; sq.jump_imm = 0; sq.branch_imm = 0; sq.jr_target = 0;
        idle(1);
        @(negedge clk);
        now("rst_pc", FPC, 0); now("rst_dpc", DPC, 0); now("rst_dp4", DP4, 4);
        now("rst_req", REQ, 0); now("rst_ifv", IFV, 0); now("rst_fls", FLS, 0);
        cycle();
        reset = 0;
        now("boot_req", REQ, 0); nxt("f1_req", REQ, 1); nxt("f1_pc", FPC, 0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            now("seq_ifv", IFV, 1); now("seq_pc", FPC, 4 * i);
            nxt("seq_npc", FPC, 4 * i + 4); nxt("seq_dpc", DPC, 4 * i);
            cycle();
        end
        redirect_to(32'h1000_0010);
        sq.dec_valid = 1; sq.jump = 1; sq.jump_imm = 26'h000_0040;
        now("j_fls", FLS, 1); now("j_ifv", IFV, 0);
        nxt("j_pc", FPC, 32'h1000_0100); nxt("j_dpc", DPC, 32'h1000_0010);
        cycle();
        redirect_to(32'h100);
        sq.dec_valid = 1; sq.branch_taken = 1; sq.branch_imm = 16'hFFFE;
        now("br_fls", FLS, 1); now("br_ifv", IFV, 0); nxt("br_pc", FPC, 32'h0FC);
        cycle();
        redirect_to(32'hFFFF_FFF8);
        sq.dec_valid = 1; sq.branch_taken = 1; sq.branch_imm = 16'h0002;
        nxt("brw_pc", FPC, 32'h4);
        cycle();
        idle(1); sq.dec_valid = 1; sq.jr = 1; sq.jump = 1; sq.branch_taken = 1; sq.jr_target = 32'h2003;
        nxt("jrp_pc", FPC, 32'h2000);
        cycle();
        redirect_to(32'h200);
        idle(0); sq.dec_valid = 1; sq.jump = 1; sq.jump_imm = 26'h10;
        now("pd_fls", FLS, 1); now("pd_ifv", IFV, 0); nxt("pd_hold", FPC, 32'h204);
        cycle();
        for (int i = 0; i < 2; i++) begin
            idle(0);
            now("pd_fls0", FLS, 0); now("pd_req", REQ, 1); nxt("pd_hold", FPC, 32'h204);
            cycle();
        end
        idle(1);
        now("pd_ack_ifv", IFV, 0); nxt("pd_tgt", FPC, 32'h40); nxt("pd_dpc", DPC, 32'h200);
        cycle();
        idle(1); sq.stall = 1;
        now("st_ifv", IFV, 0); nxt("st_req", REQ, 0); nxt("st_pc", FPC, 32'h40);
        cycle();
        idle(1); sq.stall = 1;
        now("hold_ifv", IFV, 0); nxt("hold_req", REQ, 0); nxt("hold_pc", FPC, 32'h40);
        cycle();
        idle(0);
        nxt("rf_req", REQ, 1); nxt("rf_pc", FPC, 32'h40);
        cycle();
        idle(1);
        now("rf_ifv", IFV, 1); nxt("rf_dpc", DPC, 32'h40); nxt("rf_npc", FPC, 32'h44);
        cycle();
        idle(0); sq.dec_valid = 1; sq.jr = 1; sq.jr_target = 32'h300;
        nxt("ow1_pc", FPC, 32'h44);
        cycle();
        idle(0); sq.dec_valid = 1; sq.jr = 1; sq.jr_target = 32'h500;
        nxt("ow2_pc", FPC, 32'h44);
        cycle();
        idle(1);
        now("ow_ifv", IFV, 0); nxt("ow_pc", FPC, 32'h500);
        cycle();
        idle(0); sq.dec_valid = 1; sq.jr = 1; sq.jr_target = 32'h700;
        nxt("mr_pc", FPC, 32'h500);
        cycle();
        idle(1); reset = 1;
        now("mr_rpc", FPC, 0); now("mr_req", REQ, 0); now("mr_dpc", DPC, 0); now("mr_ifv", IFV, 0);
        nxt("mr_hold", FPC, 0);
        cycle();
        reset = 0;
        now("mr_boot", REQ, 0); nxt("mr_req1", REQ, 1); nxt("mr_pc0", FPC, 0);
        cycle();
        now("mr_ifv1", IFV, 1); nxt("mr_npc", FPC, 4); nxt("mr_ndpc", DPC, 0);
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
